// File: rtl/rvvi_tx_pkg.sv
// Shared types and constants for the RVVI transmit scheduler.
package rvvi_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } tx_state_e;

  typedef enum logic {
    SRC_NEW    = 1'b0,
    SRC_REPLAY = 1'b1
  } tx_src_e;

  localparam int unsigned StatsW = 32;

endpackage

// File: rtl/rvvi_tx_pacer.sv
// Loadable down-counter that times the inter-frame gap; gap_done_o marks the last gap cycle.
module rvvi_tx_pacer #(
  parameter int unsigned GAPW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [GAPW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            gap_done_o
);

  logic [GAPW-1:0] cnt_d, cnt_q;

  // Load wins over decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAPW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gap_done_o = (cnt_q == GAPW'(1));

endmodule

// File: rtl/rvvi_tx_scheduler.sv
// Shares the RVVI Ethernet transmit path between fresh trace packets and active-list replays.
// Replay has priority; a programmable gap follows each transfer; a stuck-ack timeout is flagged.
// Optional per-source transfer counters are built when RVVI_TX_STATS_EN is defined.
module rvvi_tx_scheduler
  import rvvi_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 792,
  parameter int unsigned GAPW  = 8,
  parameter int unsigned TOW   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              new_valid_i,
  input  logic [WIDTH-1:0]  new_data_i,
  output logic              new_ready_o,
  input  logic              replay_valid_i,
  input  logic [WIDTH-1:0]  replay_data_i,
  output logic              replay_stall_o,
  input  logic              list_wait_i,
  input  logic              list_full_i,
  input  logic              ack_seen_i,
  input  logic              list_empty_i,
  input  logic [GAPW-1:0]   gap_cycles_i,
  input  logic [TOW-1:0]    timeout_cycles_i,
  output logic              tx_valid_o,
  output logic [WIDTH-1:0]  tx_data_o,
  input  logic              tx_ready_i,
  output logic              tx_is_replay_o,
  output logic              timeout_err_o,
  output logic [StatsW-1:0] new_count_o,
  output logic [StatsW-1:0] replay_count_o
);

  tx_state_e        state_d, state_q;
  logic             stall_q;
  logic             tx_valid_q;
  logic [WIDTH-1:0] tx_data_q;
  tx_src_e          tx_src_q;
  logic             sel_replay, sel_new, tx_fire, gap_load, gap_done;

  // Replay is only honoured while the stall is released, i.e. in the capture cycle.
  assign sel_replay = (state_q == S_IDLE) && !stall_q && replay_valid_i;
  assign sel_new    = (state_q == S_IDLE) && !sel_replay && new_valid_i &&
                      !list_wait_i && !list_full_i;
  assign tx_fire    = (state_q == S_HOLD) && tx_ready_i;
  assign gap_load   = tx_fire && (gap_cycles_i != '0);

  rvvi_tx_pacer #(
    .GAPW (GAPW)
  ) u_pacer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (gap_load),
    .load_val_i (gap_cycles_i),
    .dec_i      (state_q == S_GAP),
    .gap_done_o (gap_done)
  );

  // Next-state decode for the capture / hold / gap sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sel_replay || sel_new) state_d = S_HOLD;
      S_HOLD:  if (tx_ready_i) state_d = (gap_cycles_i != '0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State plus registered outputs; stall comes up high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stall_q    <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_src_q   <= SRC_NEW;
    end else begin
      state_q    <= state_d;
      stall_q    <= (state_d != S_IDLE);
      tx_valid_q <= (state_d == S_HOLD);
      if (sel_replay) begin
        tx_data_q <= replay_data_i;
        tx_src_q  <= SRC_REPLAY;
      end else if (sel_new) begin
        tx_data_q <= new_data_i;
        tx_src_q  <= SRC_NEW;
      end
    end
  end

  assign new_ready_o    = sel_new;
  assign replay_stall_o = stall_q;
  assign tx_valid_o     = tx_valid_q;
  assign tx_data_o      = tx_data_q;
  assign tx_is_replay_o = (tx_src_q == SRC_REPLAY);

  logic [TOW-1:0] to_cnt_d, to_cnt_q;
  logic           to_err_d, to_err_q;

  // Ack-timeout: saturating count of cycles without an ack while the list holds entries.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (ack_seen_i || list_empty_i) begin
      to_cnt_d = '0;
    end else if (!(&to_cnt_q)) begin
      to_cnt_d = to_cnt_q + TOW'(1);
    end
    to_err_d = to_err_q ||
               ((timeout_cycles_i != '0) && (to_cnt_d == timeout_cycles_i));
  end

  // Timeout registers; the error is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err_o = to_err_q;

`ifdef RVVI_TX_STATS_EN
  logic [StatsW-1:0] new_cnt_q, rep_cnt_q;

  // Per-source transfer counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_cnt_q <= '0;
      rep_cnt_q <= '0;
    end else if (tx_fire) begin
      if (tx_src_q == SRC_REPLAY) begin
        rep_cnt_q <= rep_cnt_q + StatsW'(1);
      end else begin
        new_cnt_q <= new_cnt_q + StatsW'(1);
      end
    end
  end

  assign new_count_o    = new_cnt_q;
  assign replay_count_o = rep_cnt_q;
`else
  assign new_count_o    = '0;
  assign replay_count_o = '0;
`endif

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Directed bench for rvvi_tx_scheduler with hand-computed expectations.
module tb_rvvi_tx_scheduler;

  localparam int unsigned W    = 792;
  localparam int unsigned GAPW = 8;
  localparam int unsigned TOW  = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic            new_valid, new_ready, replay_valid, replay_stall;
  logic [W-1:0]    new_data, replay_data, tx_data;
  logic            list_wait, list_full, ack_seen, list_empty;
  logic [GAPW-1:0] gap_cycles;
  logic [TOW-1:0]  timeout_cycles;
  logic            tx_valid, tx_ready, tx_is_replay, timeout_err;
  logic [31:0]     new_count, replay_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int new_idx = 0;
  logic nr_seen = 1'b0;

  int           t_q[$];
  logic [W-1:0] d_q[$];
  logic         r_q[$];
  int           s_q[$];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [7:0] b);
    mk = {99{b}};
  endfunction

  assign new_data = mk(new_idx[7:0]);

  rvvi_tx_scheduler #(
    .WIDTH (W),
    .GAPW  (GAPW),
    .TOW   (TOW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .new_valid_i      (new_valid),
    .new_data_i       (new_data),
    .new_ready_o      (new_ready),
    .replay_valid_i   (replay_valid),
    .replay_data_i    (replay_data),
    .replay_stall_o   (replay_stall),
    .list_wait_i      (list_wait),
    .list_full_i      (list_full),
    .ack_seen_i       (ack_seen),
    .list_empty_i     (list_empty),
    .gap_cycles_i     (gap_cycles),
    .timeout_cycles_i (timeout_cycles),
    .tx_valid_o       (tx_valid),
    .tx_data_o        (tx_data),
    .tx_ready_i       (tx_ready),
    .tx_is_replay_o   (tx_is_replay),
    .timeout_err_o    (timeout_err),
    .new_count_o      (new_count),
    .replay_count_o   (replay_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nr_seen) new_idx <= new_idx + 1;
  end

  // Mid-cycle monitor: transfers complete at the coming edge, numbered cyc+1.
  always @(negedge clk) begin
    nr_seen = new_ready;
    if (tx_valid && tx_ready) begin
      t_q.push_back(cyc + 1);
      d_q.push_back(tx_data);
      r_q.push_back(tx_is_replay);
    end
    if (!replay_stall) s_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    t_q.delete();
    d_q.delete();
    r_q.delete();
    s_q.delete();
  endtask

  int fall_c, win_n, win_a, win_b;
  logic ok_a, ok_b, ok_c;
  logic [W-1:0] held;
  logic [31:0] exp_new, exp_rep;

  initial begin
    reset = 1'b1; new_valid = 1'b0; replay_valid = 1'b0; replay_data = mk(8'hC3);
    list_wait = 1'b0; list_full = 1'b0; ack_seen = 1'b0; list_empty = 1'b1;
    gap_cycles = '0; timeout_cycles = '0; tx_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_stall", replay_stall, 1);
    chk("rst_new_ready", new_ready, 0);
    chk("rst_is_replay", tx_is_replay, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout", timeout_err, 0);
    step();
    reset = 1'b0;

    // Fresh-only stream, no gap.
    clear_mon();
    new_valid = 1'b1;
    repeat (7) step();
    new_valid = 1'b0;
    repeat (4) step();
    chk("a_count", t_q.size(), 4);
    if (t_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("a_data", d_q[i], mk(8'(i)));
        chk("a_is_replay", r_q[i], 0);
      end
      for (int i = 1; i < 4; i++) chk("a_spacing", t_q[i] - t_q[i-1], 2);
    end

    // Replay and fresh together: replay first, fresh next.
    clear_mon();
    replay_valid = 1'b1;
    new_valid = 1'b1;
    @(negedge clk);
    chk("b_new_ready", new_ready, 0);
    step();
    replay_valid = 1'b0;
    repeat (2) step();
    new_valid = 1'b0;
    repeat (3) step();
    chk("b_count", t_q.size(), 2);
    if (t_q.size() == 2) begin
      chk("b_rep_data", d_q[0], mk(8'hC3));
      chk("b_rep_flag", r_q[0], 1);
      chk("b_new_data", d_q[1], mk(8'd4));
      chk("b_new_flag", r_q[1], 0);
    end

    // List full, then list waiting, hold fresh packets off.
    clear_mon();
    list_full = 1'b1;
    new_valid = 1'b1;
    @(negedge clk);
    chk("c_full_new_ready", new_ready, 0);
    step();
    list_full = 1'b0;
    list_wait = 1'b1;
    ok_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (new_ready) ok_a = 1'b0;
      step();
    end
    chk("c_wait_new_ready", ok_a, 1);
    list_wait = 1'b0;
    fall_c = cyc;
    step();
    new_valid = 1'b0;
    repeat (3) step();
    chk("c_count", t_q.size(), 1);
    if (t_q.size() == 1) begin
      chk("c_latency", t_q[0] - fall_c, 2);
      chk("c_data", d_q[0], mk(8'd5));
    end

    // Gap of 5 cycles between transfers.
    clear_mon();
    gap_cycles = 8'd5;
    new_valid = 1'b1;
    repeat (16) step();
    new_valid = 1'b0;
    repeat (8) step();
    chk("d_count", t_q.size(), 3);
    if (t_q.size() == 3) begin
      chk("d_spacing1", t_q[1] - t_q[0], 7);
      chk("d_spacing2", t_q[2] - t_q[1], 7);
      chk("d_data", d_q[2], mk(8'd8));
      win_n = 0; win_a = -1; win_b = -1;
      foreach (s_q[i]) begin
        if (s_q[i] >= t_q[0] && s_q[i] < t_q[2]) begin
          if (win_n == 0) win_a = s_q[i];
          else win_b = s_q[i];
          win_n++;
        end
      end
      chk("d_stall_low_n", win_n, 2);
      chk("d_stall_low_1", win_a, t_q[0] + 5);
      chk("d_stall_low_2", win_b, t_q[1] + 5);
    end

    // Back-pressure from the framer.
    clear_mon();
    gap_cycles = '0;
    tx_ready = 1'b0;
    new_valid = 1'b1;
    step();
    new_valid = 1'b0;
    held = mk(8'd9);
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!tx_valid) ok_a = 1'b0;
      if (tx_data !== held) ok_b = 1'b0;
      if (!replay_stall) ok_c = 1'b0;
      step();
    end
    chk("e_valid_held", ok_a, 1);
    chk("e_data_stable", ok_b, 1);
    chk("e_stall_held", ok_c, 1);
    tx_ready = 1'b1;
    repeat (2) step();
    chk("e_count", t_q.size(), 1);
    if (t_q.size() == 1) chk("e_data", d_q[0], held);

    // Ack timeout.
    timeout_cycles = 20'd16;
    list_empty = 1'b0;
    repeat (15) step();
    @(negedge clk);
    chk("f_timeout_15", timeout_err, 0);
    step();
    @(negedge clk);
    chk("f_timeout_16", timeout_err, 1);
    step();
    ack_seen = 1'b1;
    step();
    ack_seen = 1'b0;
    @(negedge clk);
    chk("f_timeout_sticky", timeout_err, 1);

`ifdef RVVI_TX_STATS_EN
    exp_new = 32'd10;
    exp_rep = 32'd1;
`else
    exp_new = 32'd0;
    exp_rep = 32'd0;
`endif
    chk("g_new_count", new_count, exp_new);
    chk("g_replay_count", replay_count, exp_rep);

    // Reset while a packet is held: it is dropped.
    step();
    list_empty = 1'b1;
    tx_ready = 1'b0;
    new_valid = 1'b1;
    step();
    new_valid = 1'b0;
    @(negedge clk);
    chk("h_held_before_rst", tx_valid, 1);
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("h_valid_dropped", tx_valid, 0);
    chk("h_timeout_cleared", timeout_err, 0);
    chk("h_stall_rst", replay_stall, 1);
    chk("h_new_count_rst", new_count, 0);
    step();
    reset = 1'b0;
    tx_ready = 1'b1;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
